// File: rtl/adder_lin_ctrl.sv
// Sequencing controller for the 8-operand ripple adder: gathers a frame of operands,
// launches them, waits out the multicycle settle time and hands the captured sum downstream.
module adder_lin_ctrl #(
   parameter int WIDTH         = 7,
   parameter int NUM_OPS       = 8,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_ci,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] op_c,
   output logic [WIDTH-1:0] op_d,
   output logic [WIDTH-1:0] op_e,
   output logic [WIDTH-1:0] op_f,
   output logic [WIDTH-1:0] op_g,
   output logic [WIDTH-1:0] op_h,
   output logic             adder_ci,
   input  logic [WIDTH-1:0] adder_s,
   input  logic             adder_co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_co,
   output logic             busy
);

   localparam int IDXW = $clog2(NUM_OPS);
   localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NUM_OPS - 1);
   localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      COLLECT,
      SETTLE,
      HOLD
   } state_t;

   state_t           state;
   logic [IDXW-1:0]  idx;
   logic [3:0]       count;
   logic [WIDTH-1:0] ops [NUM_OPS];

   // Handshake flags depend on the state register alone, so no input reaches them combinationally.
   assign in_ready = (state == COLLECT);
   assign busy     = (state == SETTLE) || (state == HOLD);

   assign op_a = ops[0];
   assign op_b = ops[1];
   assign op_c = ops[2];
   assign op_d = ops[3];
   assign op_e = ops[4];
   assign op_f = ops[5];
   assign op_g = ops[6];
   assign op_h = ops[7];

   // Slots are cleared on every handshake so a short frame leaves the unused adder inputs at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         idx       <= '0;
         count     <= '0;
         adder_ci  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_co    <= 1'b0;
         for (int i = 0; i < NUM_OPS; i++) begin
            ops[i] <= '0;
         end
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  ops[idx] <= in_data;
                  if (idx == LAST_IDX || in_last) begin
                     adder_ci <= in_ci;
                     count    <= SETTLE_INIT;
                     state    <= SETTLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            // The ripple chain is a multicycle path; only sample it once the count runs out.
            SETTLE: begin
               if (count == 4'd0) begin
                  out_sum   <= adder_s;
                  out_co    <= adder_co;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  count <= count - 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  adder_ci  <= 1'b0;
                  idx       <= '0;
                  state     <= COLLECT;
                  for (int i = 0; i < NUM_OPS; i++) begin
                     ops[i] <= '0;
                  end
               end
            end
            default: begin
               state <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_lin_ctrl.sv
// Directed bench for adder_lin_ctrl with a behavioural adder_lin model on each controller;
// a second instance with SETTLE_CYCLES=1 covers the shortest settle time.
module tb_adder_lin_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_valid1;
   logic [6:0] in_data;
   logic       in_last;
   logic       in_ci;
   logic       out_ready;

   logic       in_ready, adder_ci, adder_co, out_valid, out_co, busy;
   logic [6:0] op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h, adder_s, out_sum;

   logic       in_ready1, adder_ci1, adder_co1, out_valid1, out_co1, busy1;
   logic [6:0] op_a1, op_b1, op_c1, op_d1, op_e1, op_f1, op_g1, op_h1, adder_s1, out_sum1;

   logic [9:0] model_full;
   logic [9:0] model_full1;

   int assertCount = 0;
   int failCount   = 0;

   // Behavioural adder_lin: 8 operands plus carry-in, truncated to WIDTH+1 bits.
   assign model_full = 10'(op_a) + 10'(op_b) + 10'(op_c) + 10'(op_d) + 10'(op_e)
                     + 10'(op_f) + 10'(op_g) + 10'(op_h) + 10'(adder_ci);
   assign adder_s  = model_full[6:0];
   assign adder_co = model_full[7];

   assign model_full1 = 10'(op_a1) + 10'(op_b1) + 10'(op_c1) + 10'(op_d1) + 10'(op_e1)
                      + 10'(op_f1) + 10'(op_g1) + 10'(op_h1) + 10'(adder_ci1);
   assign adder_s1  = model_full1[6:0];
   assign adder_co1 = model_full1[7];

   adder_lin_ctrl #(.WIDTH(7), .NUM_OPS(8), .SETTLE_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_ci(in_ci),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .op_e(op_e), .op_f(op_f), .op_g(op_g), .op_h(op_h),
      .adder_ci(adder_ci), .adder_s(adder_s), .adder_co(adder_co),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_co(out_co), .busy(busy)
   );

   adder_lin_ctrl #(.WIDTH(7), .NUM_OPS(8), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
      .in_last(in_last), .in_ci(in_ci),
      .op_a(op_a1), .op_b(op_b1), .op_c(op_c1), .op_d(op_d1),
      .op_e(op_e1), .op_f(op_f1), .op_g(op_g1), .op_h(op_h1),
      .adder_ci(adder_ci1), .adder_s(adder_s1), .adder_co(adder_co1),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_sum(out_sum1), .out_co(out_co1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Presents one beat to the SETTLE_CYCLES=3 controller; returns 1 time unit after the accepting edge.
   task automatic applyStimulus(input logic [6:0] d, input logic last, input logic ci);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_ci    = ci;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_ci    = 1'b0;
   endtask

   task automatic waitResult();
      int cycles;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (!out_valid) checkOutput("result_timeout", 32'(out_valid), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_ci     = 1'b0;
      out_ready = 1'b1;
      #2;
      checkOutput("reset_op_a", 32'(op_a), 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_adder_ci", 32'(adder_ci), 32'd0);
      #10;
      rst = 1'b0;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

      // Full frame 1..8: latency and in_ready low window
      for (int i = 1; i <= 8; i++) applyStimulus(7'(i), 1'b0, 1'b0);
      checkOutput("full_in_ready_T", 32'(in_ready), 32'd0);
      checkOutput("full_busy_T", 32'(busy), 32'd1);
      checkOutput("full_valid_T", 32'(out_valid), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("full_valid_T%0d", k), 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
         checkOutput($sformatf("full_in_ready_T%0d", k), 32'(in_ready), 32'd0);
      end
      checkOutput("full_sum", 32'(out_sum), 32'd36);
      checkOutput("full_co", 32'(out_co), 32'd0);
      checkOutput("full_op_a", 32'(op_a), 32'd1);
      checkOutput("full_op_h", 32'(op_h), 32'd8);
      @(posedge clk);
      #1;
      checkOutput("full_after_hs_valid", 32'(out_valid), 32'd0);
      checkOutput("full_after_hs_in_ready", 32'(in_ready), 32'd1);
      checkOutput("full_after_hs_op_a", 32'(op_a), 32'd0);

      // Short frame 10,20,30 with carry-in
      applyStimulus(7'd10, 1'b0, 1'b0);
      applyStimulus(7'd20, 1'b0, 1'b0);
      applyStimulus(7'd30, 1'b1, 1'b1);
      waitResult();
      checkOutput("short_op_c", 32'(op_c), 32'd30);
      checkOutput("short_op_d", 32'(op_d), 32'd0);
      checkOutput("short_op_h", 32'(op_h), 32'd0);
      checkOutput("short_adder_ci", 32'(adder_ci), 32'd1);
      checkOutput("short_sum", 32'(out_sum), 32'd61);
      checkOutput("short_co", 32'(out_co), 32'd0);
      @(posedge clk);
      #1;

      // Overflow: eight 127s plus carry-in = 1017 -> sum 0x79, co 1
      for (int i = 0; i < 8; i++) applyStimulus(7'd127, 1'b0, (i == 7) ? 1'b1 : 1'b0);
      waitResult();
      checkOutput("ovf_sum", 32'(out_sum), 32'd121);
      checkOutput("ovf_co", 32'(out_co), 32'd1);
      checkOutput("ovf_co_vs_model", 32'(out_co), 32'(adder_co));
      @(posedge clk);
      #1;

      // Backpressure with ignored beats of 99 during HOLD
      out_ready = 1'b0;
      applyStimulus(7'd1, 1'b0, 1'b0);
      applyStimulus(7'd2, 1'b1, 1'b0);
      waitResult();
      in_valid = 1'b1;
      in_data  = 7'd99;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp_sum_%0d", k), 32'(out_sum), 32'd3);
         checkOutput($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
         checkOutput($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checkOutput("bp_op_a", 32'(op_a), 32'd1);
      checkOutput("bp_op_b", 32'(op_b), 32'd2);
      checkOutput("bp_op_c_no99", 32'(op_c), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_hs_valid", 32'(out_valid), 32'd0);
      checkOutput("bp_hs_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(7'd42, 1'b0, 1'b0);
      checkOutput("next_frame_op_a", 32'(op_a), 32'd42);
      checkOutput("next_frame_op_b", 32'(op_b), 32'd0);

      // Reset mid-frame, asserted between edges
      applyStimulus(7'd43, 1'b0, 1'b0);
      applyStimulus(7'd44, 1'b0, 1'b0);
      applyStimulus(7'd45, 1'b0, 1'b0);
      checkOutput("mid_op_d_pre", 32'(op_d), 32'd45);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_op_a", 32'(op_a), 32'd0);
      checkOutput("mid_rst_op_d", 32'(op_d), 32'd0);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(7'd5, 1'b1, 1'b0);
      waitResult();
      checkOutput("mid_rst_sum", 32'(out_sum), 32'd5);
      checkOutput("mid_rst_op_b", 32'(op_b), 32'd0);
      @(posedge clk);
      #1;

      // SETTLE_CYCLES=1 instance: result one edge after the final beat
      out_ready = 1'b0;
      in_valid1 = 1'b1;
      in_data   = 7'd9;
      in_last   = 1'b1;
      in_ci     = 1'b0;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      in_last   = 1'b0;
      checkOutput("s1_valid_T", 32'(out_valid1), 32'd0);
      checkOutput("s1_busy_T", 32'(busy1), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("s1_valid_T1", 32'(out_valid1), 32'd1);
      checkOutput("s1_sum", 32'(out_sum1), 32'd9);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("s1_hs_valid", 32'(out_valid1), 32'd0);
      checkOutput("s1_hs_in_ready", 32'(in_ready1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
